// File: rtl/div32u16_seq.sv
// div32u16_seq: sequential radix-2 restoring divider.
// It divides a 32-bit unsigned dividend by a 16-bit unsigned divisor and
// produces a 16-bit quotient and a 16-bit remainder, one quotient bit per clock.
// TRUNC_BITS low quotient bits are not computed. They read as 0, and R then
// reads as 0 as well.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (A dividend, B divisor)
//   out_valid/out_ready result handshake (Q quotient, R remainder,
//                      OVF = quotient does not fit in 16 bits or B == 0)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE and is decoded from state alone.
// out_valid is high only in DONE. Q/R/OVF hold until the transfer.
// A and B are captured at accept and ignored afterwards.
//
// Overflowing operands (A[31:16] >= B) spend a single cycle in RUN.
// Their result therefore appears one edge after the accept edge.
// A normal division appears N = 16 - TRUNC_BITS edges after the accept edge.
module div32u16_seq #(
  parameter int TRUNC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [15:0] R,
  output logic        OVF
);

  generate
    if (TRUNC_BITS < 0 || TRUNC_BITS > 8) begin : g_bad_param
      $error("div32u16_seq: TRUNC_BITS must be in 0..8");
    end
  endgenerate

  localparam logic [4:0] N_STEPS = 5'(16 - TRUNC_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [16:0] p;         // partial remainder
  logic [15:0] sh;        // remaining dividend bits, MSB first
  logic [15:0] b_r;       // captured divisor
  logic [15:0] q_acc;     // quotient bits computed so far
  logic [4:0]  cnt;       // steps left in RUN
  logic        ovf_pend;  // operand overflowed at accept; RUN only publishes it

  logic [16:0] t;
  logic [16:0] t_sub;
  logic        q_bit;
  logic [15:0] q_shift;
  logic        last_step;

  // One restoring step. P < B always holds, so T < 2B fits in 17 bits
  // and T - B cannot wrap when it is selected.
  always_comb begin
    t         = {p[15:0], sh[15]};
    t_sub     = t - {1'b0, b_r};
    q_bit     = (t >= {1'b0, b_r});
    q_shift   = {q_acc[14:0], q_bit};
    last_step = (cnt == 5'd1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p        <= '0;
      sh       <= '0;
      b_r      <= '0;
      q_acc    <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      Q        <= '0;
      R        <= '0;
      OVF      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b_r   <= B;
            q_acc <= '0;
            if (A[31:16] >= B) begin
              ovf_pend <= 1'b1;
              cnt      <= 5'd1;
              p        <= '0;
              sh       <= '0;
            end else begin
              ovf_pend <= 1'b0;
              cnt      <= N_STEPS;
              p        <= {1'b0, A[31:16]};
              sh       <= A[15:0];
            end
          end
        end
        RUN: begin
          cnt <= cnt - 5'd1;
          if (ovf_pend) begin
            Q   <= 16'hFFFF;
            R   <= 16'h0000;
            OVF <= 1'b1;
          end else begin
            p     <= q_bit ? t_sub : t;
            sh    <= {sh[14:0], 1'b0};
            q_acc <= q_shift;
            if (last_step) begin
              Q   <= q_shift << TRUNC_BITS;
              R   <= (TRUNC_BITS == 0) ? (q_bit ? t_sub[15:0] : t[15:0]) : 16'h0000;
              OVF <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32u16_seq.sv
// Bench for div32u16_seq. It uses two instances, with TRUNC_BITS = 0 and 4.
// Each table row is applied to one instance. Its expected {OVF,Q,R} goes
// onto a queue at accept and is popped when out_valid appears. Further
// sequences cover random operands, backpressure and reset in mid-run.
module tb_div32u16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv0 = 1'b0, iv4 = 1'b0;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
  logic        out_ready = 1'b0;

  logic        ir0, ov0, ovf0, ir4, ov4, ovf4;
  logic [15:0] q0, r0, q4, r4;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  div32u16_seq #(.TRUNC_BITS(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a), .B(b),
    .out_valid(ov0), .out_ready(out_ready), .Q(q0), .R(r0), .OVF(ovf0)
  );

  div32u16_seq #(.TRUNC_BITS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a), .B(b),
    .out_valid(ov4), .out_ready(out_ready), .Q(q4), .R(r4), .OVF(ovf4)
  );

  typedef struct {
    bit          t4;
    logic [31:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: floor quotient with low bits cleared.
  function automatic logic [32:0] model(input bit t4, input logic [31:0] av, input logic [15:0] bv);
    logic [31:0] qf;
    logic [15:0] qq, rr;
    if (av[31:16] >= bv) return {1'b1, 16'hFFFF, 16'h0000};
    qf = av / {16'h0, bv};
    qq = qf[15:0];
    rr = 16'(av % {16'h0, bv});
    if (t4) begin
      qq = qq & 16'hFFF0;
      rr = 16'h0000;
    end
    return {1'b0, qq, rr};
  endfunction

  function automatic logic sel_ov(input bit t4);
    return t4 ? ov4 : ov0;
  endfunction

  function automatic logic [32:0] sel_res(input bit t4);
    return t4 ? {ovf4, q4, r4} : {ovf0, q0, r0};
  endfunction

  function automatic logic sel_ir(input bit t4);
    return t4 ? ir4 : ir0;
  endfunction

  // Drive one operand pair and block until accepted (leaves result pending).
  task automatic start_op(input bit t4, input logic [31:0] av, input logic [15:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    if (t4) iv4 = 1'b1; else iv0 = 1'b1;
    check("in_ready_before_accept", 64'(sel_ir(t4)), 64'd1);
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv4 = 1'b0;
    a = $urandom;
    b = 16'($urandom);
  endtask

  // Count edges after the accept edge until out_valid; compare latency and result.
  task automatic finish_op(input bit t4, input int exp_lat);
    int          lat;
    logic [32:0] e;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (sel_ov(t4)) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("result_ovf_q_r", 64'(sel_res(t4)), 64'(e));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_cleared", 64'(sel_ov(t4)), 64'd0);
    check("in_ready_after_release", 64'(sel_ir(t4)), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_q.push_back({v.ovf, v.q, v.r});
    start_op(v.t4, v.a, v.b);
    finish_op(v.t4, v.lat);
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [32:0] m;
    logic [31:0] held;

    vecs.push_back('{1'b0, 32'd100000,     16'd300,    16'd333,    16'd100, 1'b0, 16});
    vecs.push_back('{1'b0, 32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'h0,   1'b0, 16});
    vecs.push_back('{1'b0, 32'd12345,      16'd0,      16'hFFFF,   16'h0,   1'b1, 1});
    vecs.push_back('{1'b0, 32'h00050000,   16'd5,      16'hFFFF,   16'h0,   1'b1, 1});
    vecs.push_back('{1'b1, 32'd100000,     16'd3,      16'd33328,  16'h0,   1'b0, 12});
    vecs.push_back('{1'b1, 32'h00050000,   16'd5,      16'hFFFF,   16'h0,   1'b1, 1});
    vecs.push_back('{1'b0, 32'd0,          16'd1,      16'd0,      16'd0,   1'b0, 16});
    vecs.push_back('{1'b0, 32'd65535,      16'd1,      16'hFFFF,   16'd0,   1'b0, 16});
    vecs.push_back('{1'b0, 32'd7,          16'd2,      16'd3,      16'd1,   1'b0, 16});

    // Reset state
    #12;
    check("reset_in_ready0", 64'(ir0), 64'd1);
    check("reset_out_valid0", 64'(ov0), 64'd0);
    check("reset_result0", 64'({ovf0, q0, r0}), 64'd0);
    check("reset_in_ready4", 64'(ir4), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Random operands, mostly in range, against the reference model
    for (int i = 0; i < 10; i++) begin
      v.t4 = 1'($urandom_range(0, 1));
      v.b  = 16'($urandom_range(1, 65535));
      v.a  = {16'($urandom_range(0, 32'(v.b) - 1)), 16'($urandom)};
      if (i == 9) v.a[31:16] = v.b;
      m = model(v.t4, v.a, v.b);
      v.ovf = m[32];
      v.q   = m[31:16];
      v.r   = m[15:0];
      v.lat = m[32] ? 1 : (v.t4 ? 12 : 16);
      run_vec(v);
    end

    // Backpressure: result held while operands churn
    start_op(1'b0, 32'd1000, 16'd7);
    for (int k = 0; k < 16; k++) @(posedge clk);
    #1;
    check("bp_valid", 64'(ov0), 64'd1);
    held = {q0, r0};
    check("bp_value", 64'(held), 64'({16'd142, 16'd6}));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a   = $urandom;
      b   = 16'($urandom);
      iv0 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("bp_hold", 64'({ir0, ov0, q0, r0}), 64'({1'b0, 1'b1, held}));
    end
    @(negedge clk);
    iv0 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release", 64'({ir0, ov0}), 64'({1'b1, 1'b0}));

    // Reset during RUN step 7: nothing emitted for the aborted op
    start_op(1'b0, 32'd100000, 16'd300);
    for (int k = 0; k < 6; k++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", 64'({ir0, ov0, ovf0, q0, r0}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
    exp_q.delete();
    for (int k = 0; k < 3; k++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (ov0) seen++;
      end
      check("no_valid_after_abort", 64'(seen), 64'd0);
    end
    v = '{1'b0, 32'd7, 16'd2, 16'd3, 16'd1, 1'b0, 16};
    run_vec(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
